// File: rtl/pe_row_cfg_seq.sv
// Configuration/run sequencer for one CGRA PE row (LSU + NUM_PE PEs).
// Streams config words onto the row's shared bus, then runs it for a programmed length.
module pe_row_cfg_seq #(
    parameter int NUM_PE = 4,
    parameter int INST_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [INST_W-1:0] cfg_data,
    input  logic              cfg_bcast,
    input  logic              start,
    input  logic [CNT_W-1:0]  run_len,
    input  logic              abort,
    input  logic              cfg_clear,
    output logic [INST_W-1:0] PE_config,
    output logic [NUM_PE:0]   init_sel,
    output logic              init_en,
    output logic              run,
    output logic              busy,
    output logic              done,
    output logic              aborted
);

    localparam int TW = $clog2(NUM_PE + 2);
    localparam logic [TW-1:0] LAST = TW'(NUM_PE + 1);

    typedef enum logic [1:0] {IDLE, LOADED, RUN} state_t;

    state_t            state_q;
    logic [TW-1:0]     tgt_q;
    logic [TW-1:0]     tgt_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [INST_W-1:0] cfg_q;
    logic [NUM_PE:0]   sel_q;
    logic [NUM_PE:0]   sel_d;
    logic              en_q;
    logic              run_q;
    logic              done_q;
    logic              abt_q;
    logic              hs;
    logic              bcast_ok;

    assign cfg_ready = (state_q == IDLE);
    assign hs        = cfg_valid & cfg_ready;
    // A broadcast aimed at the LSU degrades to a plain LSU load.
    assign bcast_ok  = cfg_bcast && (tgt_q != '0);
    assign tgt_d     = bcast_ok ? LAST : tgt_q + TW'(1);

    // Target tgt maps to bit NUM_PE-tgt; a broadcast also covers every lower bit.
    always_comb begin
        sel_d = '0;
        for (int k = 0; k <= NUM_PE; k++) begin
            if (k == NUM_PE - int'(tgt_q) ||
                (bcast_ok && k < NUM_PE - int'(tgt_q)))
                sel_d[k] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            tgt_q   <= '0;
            cnt_q   <= '0;
            cfg_q   <= '0;
            sel_q   <= '0;
            en_q    <= 1'b0;
            run_q   <= 1'b0;
            done_q  <= 1'b0;
            abt_q   <= 1'b0;
        end else begin
            en_q   <= 1'b0;
            sel_q  <= '0;
            done_q <= 1'b0;
            abt_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (hs) begin
                        cfg_q <= cfg_data;
                        en_q  <= 1'b1;
                        sel_q <= sel_d;
                        tgt_q <= tgt_d;
                        if (tgt_d == LAST)
                            state_q <= LOADED;
                    end
                end
                LOADED: begin
                    if (cfg_clear) begin
                        state_q <= IDLE;
                        tgt_q   <= '0;
                    end else if (start) begin
                        if (run_len == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            cnt_q   <= run_len;
                            run_q   <= 1'b1;
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    // Abort outranks completion on the final cycle.
                    if (abort) begin
                        run_q   <= 1'b0;
                        abt_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= LOADED;
                    end else if (cnt_q == CNT_W'(1)) begin
                        run_q   <= 1'b0;
                        done_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= LOADED;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign PE_config = cfg_q;
    assign init_sel  = sel_q;
    assign init_en   = en_q;
    assign run       = run_q;
    assign busy      = run_q;
    assign done      = done_q;
    assign aborted   = abt_q;

endmodule
